// File: rtl/park_transform_pipe.sv
// park_transform_pipe: three-stage pipelined Park / inverse Park rotation.
// Operands are registered, then multiplied, then combined, rounded and saturated.
// A valid bit, the channel tag and the mode travel with each sample.
// A downstream stall freezes every stage.
module park_transform_pipe #(
    parameter int unsigned D_WIDTH = 18,
    parameter int unsigned Q_BITS  = 15,
    parameter int unsigned CH_W    = 2
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [D_WIDTH-1:0]  x,
    input  logic [D_WIDTH-1:0]  y,
    input  logic [D_WIDTH-1:0]  sin,
    input  logic [D_WIDTH-1:0]  cos,
    input  logic [CH_W-1:0]     ch_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [D_WIDTH-1:0]  u,
    output logic [D_WIDTH-1:0]  v,
    output logic [CH_W-1:0]     ch_out,
    output logic                sat
);

    localparam int unsigned P_W = 2 * D_WIDTH;
    localparam int unsigned S_W = P_W + 1;

    // Half an LSB of the rescaled result, added before the arithmetic shift.
    localparam logic signed [S_W-1:0] RND_HALF = S_W'(1) << (Q_BITS - 1);
    // Output clamp limits, sign-extended to the sum width.
    localparam logic signed [S_W-1:0] SAT_MAX =
        {{(S_W - D_WIDTH + 1){1'b0}}, {(D_WIDTH - 1){1'b1}}};
    localparam logic signed [S_W-1:0] SAT_MIN =
        {{(S_W - D_WIDTH + 1){1'b1}}, {(D_WIDTH - 1){1'b0}}};

    // Stage 1: registered operands.
    logic                       r1_valid;
    logic                       r1_mode;
    logic [CH_W-1:0]            r1_ch;
    logic signed [D_WIDTH-1:0]  r1_x;
    logic signed [D_WIDTH-1:0]  r1_y;
    logic signed [D_WIDTH-1:0]  r1_sin;
    logic signed [D_WIDTH-1:0]  r1_cos;

    // Stage 2: full-precision products.
    logic                       r2_valid;
    logic                       r2_mode;
    logic [CH_W-1:0]            r2_ch;
    logic signed [P_W-1:0]      r2_xc;
    logic signed [P_W-1:0]      r2_ys;
    logic signed [P_W-1:0]      r2_xs;
    logic signed [P_W-1:0]      r2_yc;

    // Stage 3: final results driving the outputs.
    logic                       r3_valid;
    logic [CH_W-1:0]            r3_ch;
    logic [D_WIDTH-1:0]         r3_u;
    logic [D_WIDTH-1:0]         r3_v;
    logic                       r3_sat;

    logic                       w_adv;
    logic signed [P_W-1:0]      w_xc;
    logic signed [P_W-1:0]      w_ys;
    logic signed [P_W-1:0]      w_xs;
    logic signed [P_W-1:0]      w_yc;
    logic signed [S_W-1:0]      w_sum_u;
    logic signed [S_W-1:0]      w_sum_v;
    logic signed [S_W-1:0]      w_rnd_u;
    logic signed [S_W-1:0]      w_rnd_v;
    logic [D_WIDTH-1:0]         w_u_sat;
    logic [D_WIDTH-1:0]         w_v_sat;
    logic                       w_u_clip;
    logic                       w_v_clip;

    // The whole pipe moves unless the output register holds an unaccepted beat.
    assign w_adv    = !r3_valid || out_ready;
    assign in_ready = w_adv;

    // Stage 1 register: capture operands, tag and mode of an accepted beat.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r1_valid <= 1'b0;
            r1_mode  <= 1'b0;
            r1_ch    <= '0;
            r1_x     <= '0;
            r1_y     <= '0;
            r1_sin   <= '0;
            r1_cos   <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_mode <= mode;
                r1_ch   <= ch_in;
                r1_x    <= x;
                r1_y    <= y;
                r1_sin  <= sin;
                r1_cos  <= cos;
            end
        end
    end

    // Sign-extend to product width so each product is exact.
    assign w_xc = P_W'(r1_x) * P_W'(r1_cos);
    assign w_ys = P_W'(r1_y) * P_W'(r1_sin);
    assign w_xs = P_W'(r1_x) * P_W'(r1_sin);
    assign w_yc = P_W'(r1_y) * P_W'(r1_cos);

    // Stage 2 register: the four products.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r2_valid <= 1'b0;
            r2_mode  <= 1'b0;
            r2_ch    <= '0;
            r2_xc    <= '0;
            r2_ys    <= '0;
            r2_xs    <= '0;
            r2_yc    <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_mode <= r1_mode;
                r2_ch   <= r1_ch;
                r2_xc   <= w_xc;
                r2_ys   <= w_ys;
                r2_xs   <= w_xs;
                r2_yc   <= w_yc;
            end
        end
    end

    // Combine products: mode 0 rotates by +angle, mode 1 by -angle.
    always_comb begin
        w_sum_u = S_W'(r2_xc) - S_W'(r2_ys);
        w_sum_v = S_W'(r2_xs) + S_W'(r2_yc);
        if (r2_mode) begin
            w_sum_u = S_W'(r2_xc) + S_W'(r2_ys);
            w_sum_v = S_W'(r2_yc) - S_W'(r2_xs);
        end
    end

    // Round half toward +inf, then drop the fractional bits.
    assign w_rnd_u = (w_sum_u + RND_HALF) >>> Q_BITS;
    assign w_rnd_v = (w_sum_v + RND_HALF) >>> Q_BITS;

    // Clamp each result to the signed output range and flag clipping.
    always_comb begin
        w_u_sat  = w_rnd_u[D_WIDTH-1:0];
        w_v_sat  = w_rnd_v[D_WIDTH-1:0];
        w_u_clip = 1'b0;
        w_v_clip = 1'b0;
        if (w_rnd_u > SAT_MAX) begin
            w_u_sat  = SAT_MAX[D_WIDTH-1:0];
            w_u_clip = 1'b1;
        end else if (w_rnd_u < SAT_MIN) begin
            w_u_sat  = SAT_MIN[D_WIDTH-1:0];
            w_u_clip = 1'b1;
        end
        if (w_rnd_v > SAT_MAX) begin
            w_v_sat  = SAT_MAX[D_WIDTH-1:0];
            w_v_clip = 1'b1;
        end else if (w_rnd_v < SAT_MIN) begin
            w_v_sat  = SAT_MIN[D_WIDTH-1:0];
            w_v_clip = 1'b1;
        end
    end

    // Stage 3 register: output beat, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r3_valid <= 1'b0;
            r3_ch    <= '0;
            r3_u     <= '0;
            r3_v     <= '0;
            r3_sat   <= 1'b0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_ch  <= r2_ch;
                r3_u   <= w_u_sat;
                r3_v   <= w_v_sat;
                r3_sat <= w_u_clip || w_v_clip;
            end
        end
    end

    assign out_valid = r3_valid;
    assign ch_out    = r3_ch;
    assign u         = r3_u;
    assign v         = r3_v;
    assign sat       = r3_sat;

endmodule
